// File: rtl/bus_trace_pkg.sv
// Shared types and entry layout for the bus trace capture block.
// Entry layout, LSB first: address, data, wr_enable.
package bus_trace_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } trace_state_e;

    localparam int ADDR_LSB = 0;

    function automatic int entry_w(input int addr_w, input int data_w);
        return addr_w + data_w + 1;
    endfunction

    function automatic int data_lsb(input int addr_w);
        return ADDR_LSB + addr_w;
    endfunction

    function automatic int we_bit(input int addr_w, input int data_w);
        return ADDR_LSB + addr_w + data_w;
    endfunction

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port trace storage: one write port, one registered read port.
// The memory array is left unreset so it maps onto block RAM.
module trace_ram #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 25,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Only the output register is cleared, so the read port powers up as zero.
    always_ff @(posedge clk) begin
        if (!resetn) rdata <= '0;
        else         rdata <= mem[raddr];
    end

endmodule

// File: rtl/bus_trace.sv
// Processor bus trace: circular capture with address/forced trigger and
// a post-trigger sample budget, read back through a registered index port.
module bus_trace
    import bus_trace_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    localparam int IW    = $clog2(DEPTH),
    localparam int EW    = entry_w(ADDR_W, DATA_W)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              arm,
    input  logic              trig_force,
    input  logic [ADDR_W-1:0] trig_addr,
    input  logic [ADDR_W-1:0] trig_mask,
    input  logic              trig_on_wr,
    input  logic [IW-1:0]     post_count,
    input  logic              bus_valid,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              wr_enable,
    input  logic [IW-1:0]     rd_index,
    output logic [EW-1:0]     rd_entry,
    output logic [1:0]        state,
    output logic              done,
    output logic [IW:0]       count,
    output logic [IW-1:0]     trig_index
);

    localparam int        DLSB = data_lsb(ADDR_W);
    localparam int        WEB  = we_bit(ADDR_W, DATA_W);
    localparam logic [IW:0] FULL = (IW+1)'(DEPTH);

    trace_state_e  st;
    logic [IW-1:0] wr_ptr;
    logic [IW-1:0] trig_slot;
    logic [IW-1:0] post_cnt;
    logic [IW:0]   cnt;
    logic          force_pend;

    logic          addr_hit;
    logic          cycle_ok;
    logic          capture;
    logic          trig_fire;
    logic [IW-1:0] trig_slot_nxt;
    logic [IW-1:0] oldest;
    logic [IW-1:0] rd_phys;
    logic [EW-1:0] wentry;

    assign addr_hit = ((address ^ trig_addr) & trig_mask) == '0;
    assign cycle_ok = !trig_on_wr || wr_enable;
    assign capture  = bus_valid && (st == ARMED || st == POST);

    // A force with no sample pins the last stored entry; with nothing stored
    // yet it is held pending and the next sample becomes the trigger.
    assign trig_fire = (st == ARMED) &&
                       ((bus_valid && ((addr_hit && cycle_ok) || trig_force || force_pend)) ||
                        (trig_force && !bus_valid && cnt != '0));
    assign trig_slot_nxt = bus_valid ? wr_ptr : wr_ptr - 1'b1;

    assign oldest     = (cnt == FULL) ? wr_ptr : '0;
    assign rd_phys    = oldest + rd_index;
    assign trig_index = trig_slot - oldest;

    always_comb begin
        wentry = '0;
        wentry[ADDR_LSB +: ADDR_W] = address;
        wentry[DLSB +: DATA_W]     = wr_enable ? wr_data : rd_data;
        wentry[WEB]                = wr_enable;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            st         <= IDLE;
            done       <= 1'b0;
            wr_ptr     <= '0;
            cnt        <= '0;
            trig_slot  <= '0;
            post_cnt   <= '0;
            force_pend <= 1'b0;
        end else if (arm) begin
            st         <= ARMED;
            done       <= 1'b0;
            wr_ptr     <= '0;
            cnt        <= '0;
            trig_slot  <= '0;
            post_cnt   <= '0;
            force_pend <= 1'b0;
        end else begin
            if (capture) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (cnt != FULL) cnt <= cnt + 1'b1;
            end
            case (st)
                ARMED: begin
                    if (trig_force && !bus_valid && cnt == '0) force_pend <= 1'b1;
                    if (trig_fire) begin
                        trig_slot  <= trig_slot_nxt;
                        // post_count is IW bits wide, so it never exceeds DEPTH-1
                        // and the trigger entry cannot be overwritten.
                        post_cnt   <= post_count;
                        force_pend <= 1'b0;
                        if (post_count == '0) begin
                            st   <= DONE;
                            done <= 1'b1;
                        end else begin
                            st <= POST;
                        end
                    end
                end
                POST: begin
                    if (bus_valid) begin
                        post_cnt <= post_cnt - 1'b1;
                        if (post_cnt == IW'(1)) begin
                            st   <= DONE;
                            done <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign state = st;
    assign count = cnt;

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_ram (
        .clk    (clk),
        .resetn (resetn),
        .we     (capture && !arm && resetn),
        .waddr  (wr_ptr),
        .wdata  (wentry),
        .raddr  (rd_phys),
        .rdata  (rd_entry)
    );

endmodule
